uart_tx_frame: RTL

UART transmit path: the counterpart of the receive-side sampler/deserializer.
- Accepts one parallel byte per handshake and emits a standard asynchronous frame on TX_OUT: start bit, 8 data bits LSB-first, optional parity, one stop bit.
- Bit timing comes from an internal prescale counter in the CLK domain.
- Sits between the host/FIFO interface and the serial pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 37 +++
 rtl/uart_tx_frame.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and line-level constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the accepted byte and parity type; presents data[bit_idx] LSB-first and the parity bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              par_typ,
  input  logic [IDX_W-1:0]  bit_idx,
  input  logic              serial_en,
  output logic              serial_bit,
  output logic              parity_bit
);

  logic [DATA_W-1:0] data_q;
  logic              par_typ_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      data_q    <= '0;
      par_typ_q <= EVEN;
    end else if (load) begin
      data_q    <= data_in;
      par_typ_q <= par_typ;
    end
  end

  assign serial_bit = serial_en ? data_q[bit_idx] : IDLE_LEVEL;

  // Even type: total ones including parity even; odd type flips it.
  assign parity_bit = (^data_q) ^ par_typ_q;

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_W bits LSB-first, optional parity, one stop bit.
// Parity slot and PAR_EN/PAR_TYP ports exist only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Data_Valid,
  input  logic [DATA_W-1:0]     P_DATA,
`ifdef UART_TX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
`endif
  output logic                  Busy,
  output logic                  TX_OUT
);

  localparam int unsigned    IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  accept, terminal;
  logic                  par_en, par_typ;
  logic                  serial_bit, parity_bit;

  assign accept   = (state_q == IDLE) && Data_Valid;
  assign terminal = (cnt_q == period_q - PRESCALE_W'(1));

`ifdef UART_TX_PARITY_EN
  logic par_en_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      par_en_q <= 1'b0;
    end else if (accept) begin
      par_en_q <= PAR_EN;
    end
  end

  assign par_en  = par_en_q;
  assign par_typ = PAR_TYP;
`else
  assign par_en  = 1'b0;
  assign par_typ = EVEN;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    period_d = period_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (accept) begin
          state_d  = START;
          period_d = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
        end
      end
      START: begin
        if (terminal) begin
          state_d = DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      DATA: begin
        if (terminal) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = par_en ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      PARITY: begin
        if (terminal) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      STOP: begin
        if (terminal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + PRESCALE_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line level is derived from the next state so TX_OUT flips in step with the state register.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      IDLE:    tx_d = IDLE_LEVEL;
      START:   tx_d = START_BIT;
      DATA:    tx_d = serial_bit;
      PARITY:  tx_d = parity_bit;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      tx_q     <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
    end
  end

  uart_tx_serializer #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_serializer (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .load       (accept),
    .data_in    (P_DATA),
    .par_typ    (par_typ),
    .bit_idx    (idx_d),
    .serial_en  (state_d == DATA),
    .serial_bit (serial_bit),
    .parity_bit (parity_bit)
  );

  assign Busy   = (state_q != IDLE);
  assign TX_OUT = tx_q;

endmodule
